// File: rtl/resource_requester.sv
// Resource requester: queues client addresses and issues them one at a time to a shared
// resource. Each tagged response, or a timeout, is returned to the client in request order.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 12
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module resource_requester #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  input  logic [`ADDRESS_WIDTH-1:0] req_address,
  output logic                      req_ready,
  output logic                      rsp_valid,
  output logic [`DATA_WIDTH-1:0]    rsp_data,
  output logic                      rsp_error,
  input  logic                      rsp_ready,
  output logic [`ADDRESS_WIDTH-1:0] rs_address,
  output logic [`ID_WIDTH-1:0]      rs_id,
  output logic                      rs_valid,
  input  logic [`DATA_WIDTH-1:0]    rs_data,
  input  logic [`ID_WIDTH-1:0]      rs_resp_id,
  input  logic                      rs_resp_valid,
  input  logic                      rs_ready
);
  localparam int AW = `ADDRESS_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam int IW = `ID_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   PTR_ONE     = 1;
  localparam logic [IW-1:0] TAG_ONE     = 1;
  localparam logic [7:0]    TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  state_t        r_state;
  logic [AW-1:0] r_mem [FIFO_DEPTH];
  logic [PW:0]   r_wr_ptr;
  logic [PW:0]   r_rd_ptr;
  logic [IW-1:0] r_tag;
  logic [7:0]    r_timer;
  logic          r_rs_valid;
  logic [AW-1:0] r_rs_address;
  logic [IW-1:0] r_rs_id;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_error;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_match;

  // The extra pointer MSB separates full from empty when the index bits are equal.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push  = req_valid && !w_full;
  assign w_match = rs_resp_valid && (rs_resp_id == r_rs_id);

  // NOTE: queue storage is deliberately not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= req_address;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_wr_ptr <= '0;
    else if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
  end

  // NOTE: every state register uses <= so each branch sees the values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_rd_ptr     <= '0;
      r_tag        <= '0;
      r_timer      <= '0;
      r_rs_valid   <= 1'b0;
      r_rs_address <= '0;
      r_rs_id      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A response still held high by the resource blocks the next issue.
          if (!w_empty && rs_ready && !rs_resp_valid) begin
            r_state      <= ISSUE;
            r_rs_valid   <= 1'b1;
            r_rs_address <= r_mem[r_rd_ptr[PW-1:0]];
            r_rs_id      <= r_tag;
          end
        end
        ISSUE: begin
          r_state    <= WAIT;
          r_rs_valid <= 1'b0;
          r_rd_ptr   <= r_rd_ptr + PTR_ONE;
          r_tag      <= r_tag + TAG_ONE;
          r_timer    <= '0;
        end
        WAIT: begin
          if (w_match) begin
            r_state     <= DELIVER;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= rs_data;
            r_rsp_error <= 1'b0;
          end else if (r_timer == TIMEOUT_CNT) begin
            r_state     <= DELIVER;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b1;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        DELIVER: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = !w_full;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_error  = r_rsp_error;
  assign rs_valid   = r_rs_valid;
  assign rs_address = r_rs_address;
  assign rs_id      = r_rs_id;

endmodule

// File: tb/tb_resource_requester.sv
// Bench for resource_requester: a behavioural resource stub, a response scoreboard,
// and directed scenarios (single, duplicate hold, backpressure, wrong id, timeout, reset).
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 12
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_resource_requester;
  localparam int AW         = `ADDRESS_WIDTH;
  localparam int DW         = `DATA_WIDTH;
  localparam int IW         = `ID_WIDTH;
  localparam int TB_TIMEOUT = 20;

  typedef enum int {ST_NORMAL, ST_WRONG_ID, ST_SILENT} stub_mode_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_error;
  logic          rsp_ready = 1'b1;
  logic [AW-1:0] rs_address;
  logic [IW-1:0] rs_id;
  logic          rs_valid;
  logic [DW-1:0] rs_data = '0;
  logic [IW-1:0] rs_resp_id = '0;
  logic          rs_resp_valid = 1'b0;
  logic          rs_ready = 1'b1;

  resource_requester #(.FIFO_DEPTH(4), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_address(req_address), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .rsp_ready(rsp_ready),
    .rs_address(rs_address), .rs_id(rs_id), .rs_valid(rs_valid),
    .rs_data(rs_data), .rs_resp_id(rs_resp_id), .rs_resp_valid(rs_resp_valid), .rs_ready(rs_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rsp    = 0;
  int n_issue  = 0;
  int rise_cyc = 0;
  int first_valid_cyc = 0;
  int issue_hist[$];
  int fall_hist[$];
  exp_t          sb_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [IW-1:0] exp_tag = '0;

  stub_mode_t    stub_mode  = ST_NORMAL;
  int            stub_delay = 3;
  int            stub_hold  = 1;
  bit            st_busy    = 1'b0;
  bit            st_wrong   = 1'b0;
  int            st_cnt     = 0;
  int            st_hold    = 0;
  logic [IW-1:0] st_id      = '0;
  logic [AW-1:0] st_addr    = '0;
  logic          prev_rs_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
    return DW'(a) + DW'(32'h200);
  endfunction

  always @(posedge clk) cyc++;

  // Resource stub: sees DUT outputs and updates its own outputs on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      st_busy = 1'b0; st_wrong = 1'b0; rs_resp_valid = 1'b0; rs_data = '0; rs_resp_id = '0;
      prev_rs_valid = 1'b0;
    end else begin
      if (rs_valid && prev_rs_valid) check("rs_valid_one_cycle", 1, 0);
      if (rs_valid) begin
        n_issue++;
        issue_hist.push_back(cyc);
        if (exp_addr_q.size() == 0) check("unexpected_issue", 1, 0);
        else check("issue_addr", rs_address, exp_addr_q.pop_front());
        check("issue_id", rs_id, exp_tag);
        exp_tag++;
        if (!st_busy) begin
          st_busy = 1'b1; st_cnt = stub_delay; st_id = rs_id; st_addr = rs_address;
          st_wrong = (stub_mode == ST_WRONG_ID);
        end
      end else if (st_busy && stub_mode != ST_SILENT) begin
        if (st_cnt > 0) st_cnt--;
        else if (!rs_resp_valid) begin
          rs_resp_valid = 1'b1;
          rs_resp_id    = st_wrong ? st_id + IW'(1) : st_id;
          rs_data       = st_wrong ? ~model_data(st_addr) : model_data(st_addr);
          st_hold       = stub_hold;
          if (!st_wrong) first_valid_cyc = cyc;
        end else begin
          st_hold--;
          if (st_hold == 0) begin
            rs_resp_valid = 1'b0;
            if (st_wrong) st_wrong = 1'b0;
            else begin
              st_busy = 1'b0;
              fall_hist.push_back(cyc);
            end
          end
        end
      end
      prev_rs_valid = rs_valid;
    end
    rs_ready = !st_busy || rs_resp_valid;
  end

  // Monitor: pops the scoreboard on each client handshake and checks hold stability.
  logic          prev_valid = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_err   = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall) begin
        check("rsp_valid_held", rsp_valid, 1);
        check("rsp_data_stable", rsp_data, prev_data);
        check("rsp_error_stable", rsp_error, prev_err);
      end
      if (rsp_valid && !prev_valid) rise_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_error", rsp_error, e.err);
        end
        n_rsp++;
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_valid = rsp_valid;
      prev_data  = rsp_data;
      prev_err   = rsp_error;
    end else begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end
  end

  task automatic expect_req(input logic [AW-1:0] a, input bit with_rsp);
    exp_t e;
    exp_addr_q.push_back(a);
    if (with_rsp) begin
      e.data = model_data(a);
      e.err  = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  // Called just after a rising edge; drives one push per cycle.
  task automatic push_burst(input logic [AW-1:0] a0, input int n);
    for (int i = 0; i < n; i++) begin
      req_valid   = 1'b1;
      req_address = a0 + AW'(i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int k = 0;
    while (n_rsp < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("rsp_count", n_rsp, target);
  endtask

  task automatic wait_issue(input int target, input int budget);
    int k = 0;
    while (n_issue < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("issue_count", n_issue, target);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_error"}, rsp_error, 0);
    check({tag, "_rs_valid"}, rs_valid, 0);
    check({tag, "_rs_address"}, rs_address, 0);
    check({tag, "_rs_id"}, rs_id, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_i;
    int base_f;
    int saved_issue;
    exp_t e;

    #12 check_reset("por");
    #11 reset_n = 1'b1;

    // Single request: data is address + 0x200, first tag 0, one cycle to capture.
    @(posedge clk); #1;
    expect_req(12'h012, 1);
    push_burst(12'h012, 1);
    wait_rsp(1, 60);
    check("capture_latency", rise_cyc - first_valid_cyc, 1);

    // Resource holds its response 16 cycles: one delivery, next issue after it falls.
    stub_delay = 2; stub_hold = 16;
    @(posedge clk); #1;
    base_i = issue_hist.size();
    base_f = fall_hist.size();
    expect_req(12'h020, 1);
    expect_req(12'h021, 1);
    push_burst(12'h020, 2);
    wait_rsp(3, 200);
    repeat (30) @(negedge clk);
    check("dup_rsp_count", n_rsp, 3);
    check("issue_after_fall", issue_hist[base_i+1], fall_hist[base_f] + 1);

    // Backpressure: five pushes fill four slots plus one issued request.
    stub_delay = 1; stub_hold = 1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) expect_req(12'h030 + AW'(i), 1);
    push_burst(12'h030, 5);
    @(negedge clk);
    check("full_after_5", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_address = 12'h035;
    repeat (3) begin @(posedge clk); #1; end
    req_valid = 1'b0;
    @(negedge clk);
    check("still_full", req_ready, 0);
    check("stalled_rsp_valid", rsp_valid, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_rsp(8, 300);
    @(negedge clk);
    check("drained_ready", req_ready, 1);

    // Wrong id first, then the correct one.
    stub_mode = ST_WRONG_ID; stub_delay = 2; stub_hold = 3;
    @(posedge clk); #1;
    expect_req(12'h040, 1);
    push_burst(12'h040, 1);
    wait_rsp(9, 80);
    repeat (10) @(negedge clk);
    stub_mode = ST_NORMAL;

    // Timeout: silent resource, error response TIMEOUT+2 cycles after ISSUE.
    stub_mode = ST_SILENT;
    @(posedge clk); #1;
    expect_req(12'h050, 0);
    e.data = '0; e.err = 1'b1;
    sb_q.push_back(e);
    push_burst(12'h050, 1);
    wait_rsp(10, TB_TIMEOUT + 40);
    check("timeout_latency", rise_cyc - issue_hist[issue_hist.size()-1], TB_TIMEOUT + 2);
    st_busy = 1'b0;

    // Reset in WAIT: outputs clear at once, queue discarded, no stale response.
    saved_issue = n_issue;
    @(posedge clk); #1;
    expect_req(12'h060, 0);
    push_burst(12'h060, 2);
    wait_issue(saved_issue + 1, 20);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset("mid_wait");
    exp_addr_q.delete();
    exp_tag = '0;
    saved_issue = n_issue;
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b1;
    stub_mode = ST_NORMAL; stub_delay = 3; stub_hold = 1;
    repeat (12) @(negedge clk);
    check("no_issue_after_reset", n_issue, saved_issue);
    check("no_rsp_after_reset", n_rsp, 10);
    @(posedge clk); #1;
    expect_req(12'h070, 1);
    push_burst(12'h070, 1);
    wait_rsp(11, 60);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
